// File: rtl/seq_gen_param.sv
// seq_gen_param
// Parametrised timing-state sequencer. It steps a one-hot phase vector, and
// the matching binary index, through a programmable number of phases per
// sequence. It supports early finish, halt/resume and a count of completed
// sequences.
//
// Ports
//   clk      in   single clock, rising edge
//   clr      in   synchronous active-high reset
//   ce       in   advance enable
//   len      in   phase count for the next sequence; used only in phase 0
//                 (0 or > NSTATES selects NSTATES)
//   fin      in   finish the current sequence after this phase
//   halt     in   enter the halted condition when the sequence completes
//   resume   in   leave the halted condition (works regardless of ce)
//   state    out  one-hot phase vector, equal to 1 << phase
//   phase    out  binary phase index
//   first    out  phase 0 and not halted
//   last     out  final phase of the current sequence
//   halted   out  frozen at phase 0
//   seq_cnt  out  completed sequences, modulo 2^CW
//
// Run/halt control
//   state   | meaning
//   ST_RUN  | phases advance whenever ce is high
//   ST_HALT | frozen at phase 0 until resume
module seq_gen_param #(
  parameter int NSTATES = 6,
  parameter int CW      = 8,
  localparam int IW     = (NSTATES > 2) ? $clog2(NSTATES) : 1
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               ce,
  input  logic [IW:0]        len,
  input  logic               fin,
  input  logic               halt,
  input  logic               resume,
  output logic [NSTATES-1:0] state,
  output logic [IW-1:0]      phase,
  output logic               first,
  output logic               last,
  output logic               halted,
  output logic [CW-1:0]      seq_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} ctl_t;

  localparam logic [IW:0] NS_L = (IW+1)'(NSTATES);

  ctl_t            ctl_q, ctl_nxt;
  logic [IW-1:0]   phase_nxt;
  logic [CW-1:0]   cnt_nxt;
  logic [IW:0]     len_q, len_q_nxt;
  logic [IW:0]     len_clamp;
  logic [IW:0]     eff_len;
  logic            at_zero;
  logic            adv;
  logic            done;

  assign at_zero   = (phase == '0);
  assign len_clamp = (len == '0 || len > NS_L) ? NS_L : len;
  // len only matters in phase 0; once the sequence is under way the length
  // latched on leaving phase 0 governs.
  assign eff_len   = at_zero ? len_clamp : len_q;

  assign halted = (ctl_q == ST_HALT);
  assign first  = at_zero && !halted;
  assign last   = !halted && ((IW+1)'(phase) == eff_len - (IW+1)'(1));
  assign adv    = ce && !halted && !clr;
  assign done   = adv && (last || fin);

  // state is decoded from phase so it is always exactly one-hot.
  always_comb begin
    state        = '0;
    state[phase] = 1'b1;
  end

  always_comb begin
    ctl_nxt   = ctl_q;
    phase_nxt = phase;
    cnt_nxt   = seq_cnt;
    len_q_nxt = len_q;
    if (halted && resume) begin
      ctl_nxt = ST_RUN;
    end else if (done) begin
      phase_nxt = '0;
      cnt_nxt   = seq_cnt + CW'(1);
      ctl_nxt   = halt ? ST_HALT : ST_RUN;
    end else if (adv) begin
      phase_nxt = phase + IW'(1);
      if (at_zero) len_q_nxt = len_clamp;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ctl_q   <= ST_RUN;
      phase   <= '0;
      seq_cnt <= '0;
      len_q   <= NS_L;
    end else begin
      ctl_q   <= ctl_nxt;
      phase   <= phase_nxt;
      seq_cnt <= cnt_nxt;
      len_q   <= len_q_nxt;
    end
  end

endmodule

// File: tb/tb_seq_gen_param.sv
// tb_seq_gen_param
// Directed bench for seq_gen_param at NSTATES = 6, CW = 8. Inputs change
// 1 ns after a rising edge; outputs are checked at the same point.
module tb_seq_gen_param;

  logic       clk = 1'b0;
  logic       clr, ce, fin, halt, resume;
  logic [3:0] len;
  logic [5:0] state;
  logic [2:0] phase;
  logic       first, last, halted;
  logic [7:0] seq_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  seq_gen_param #(.NSTATES(6), .CW(8)) dut (
    .clk(clk), .clr(clr), .ce(ce), .len(len), .fin(fin), .halt(halt),
    .resume(resume), .state(state), .phase(phase), .first(first),
    .last(last), .halted(halted), .seq_cnt(seq_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_phase(input string tag, input int p);
    chk({tag, ".phase"}, 32'(phase), 32'(p));
    chk({tag, ".state"}, 32'(state), 32'(1) << p);
  endtask

  int exp_ph [6] = '{1, 1, 2, 0, 0, 1};
  logic ce_pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    clr = 1'b1; ce = 1'b0; fin = 1'b0; halt = 1'b0; resume = 1'b0; len = 4'd6;
    step();
    // reset values
    chk_phase("rst", 0);
    chk("rst.first", 32'(first), 1);
    chk("rst.last", 32'(last), 0);
    chk("rst.halted", 32'(halted), 0);
    chk("rst.cnt", 32'(seq_cnt), 0);
    len = 4'd1;
    #1;
    chk("rst.last_len1", 32'(last), 1);
    len = 4'd6;

    // full-length sequence, 13 advancing cycles
    clr = 1'b0; ce = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk_phase("full", k % 6);
      chk("full.last", 32'(last), 32'((k % 6) == 5));
    end
    chk("full.cnt", 32'(seq_cnt), 2);

    // short length with ce gaps; len change in phase 1 ignored
    clr = 1'b1;
    step();
    clr = 1'b0; len = 4'd3;
    for (int i = 0; i < 6; i++) begin
      ce = ce_pat[i];
      step();
      chk("short.phase", 32'(phase), 32'(exp_ph[i]));
      if (i == 0) len = 4'd5;
      if (i == 2) chk("short.last_lenq", 32'(last), 1);
    end
    chk("short.cnt", 32'(seq_cnt), 1);
    ce = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk_phase("len5", 4);
    chk("len5.last", 32'(last), 1);
    step();
    chk_phase("len5.wrap", 0);
    chk("len5.cnt", 32'(seq_cnt), 2);

    // early finish in phase 2, then fin together with last
    len = 4'd6;
    step(); step();
    chk_phase("fin.p2", 2);
    fin = 1'b1;
    step();
    fin = 1'b0;
    chk_phase("fin.early", 0);
    chk("fin.cnt", 32'(seq_cnt), 3);
    for (int i = 0; i < 5; i++) step();
    chk("finlast.last", 32'(last), 1);
    fin = 1'b1;
    step();
    fin = 1'b0;
    chk_phase("finlast", 0);
    chk("finlast.cnt", 32'(seq_cnt), 4);

    // halt on the last phase, ignore ce/fin/halt while halted, resume with ce low
    for (int i = 0; i < 5; i++) step();
    halt = 1'b1;
    step();
    chk("halt.halted", 32'(halted), 1);
    chk("halt.cnt", 32'(seq_cnt), 5);
    fin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_phase("halted", 0);
      chk("halted.flag", 32'(halted), 1);
      chk("halted.first", 32'(first), 0);
      chk("halted.last", 32'(last), 0);
    end
    chk("halted.cnt", 32'(seq_cnt), 5);
    fin = 1'b0; halt = 1'b0; ce = 1'b0; resume = 1'b1;
    step();
    resume = 1'b0;
    chk("resume.halted", 32'(halted), 0);
    chk("resume.first", 32'(first), 1);
    chk_phase("resume", 0);
    ce = 1'b1;
    step();
    chk_phase("resume.adv", 1);

    // length clamp: 0 and 9 both give 6 phases
    clr = 1'b1;
    step();
    clr = 1'b0; len = 4'd0;
    chk("clamp0.last", 32'(last), 0);
    for (int i = 0; i < 5; i++) step();
    chk_phase("clamp0.p5", 5);
    chk("clamp0.last5", 32'(last), 1);
    step();
    chk("clamp0.cnt", 32'(seq_cnt), 1);
    len = 4'd9;
    for (int i = 0; i < 5; i++) step();
    chk_phase("clamp9.p5", 5);
    chk("clamp9.last", 32'(last), 1);
    step();
    chk_phase("clamp9.wrap", 0);
    chk("clamp9.cnt", 32'(seq_cnt), 2);

    // fin in phase 0 is a one-phase sequence
    len = 4'd6; fin = 1'b1;
    step();
    fin = 1'b0;
    chk_phase("fin0", 0);
    chk("fin0.cnt", 32'(seq_cnt), 3);

    // len = 1: every cycle completes; counter wraps 255 -> 0
    len = 4'd1;
    for (int i = 0; i < 252; i++) step();
    chk_phase("len1", 0);
    chk("len1.last", 32'(last), 1);
    chk("len1.cnt255", 32'(seq_cnt), 255);
    step();
    chk("len1.wrap", 32'(seq_cnt), 0);

    // clr mid-sequence overrides fin/halt/resume
    len = 4'd6;
    for (int i = 0; i < 4; i++) step();
    chk_phase("mid.p4", 4);
    clr = 1'b1; fin = 1'b1; halt = 1'b1; resume = 1'b1;
    step();
    chk_phase("mid.clr", 0);
    chk("mid.halted", 32'(halted), 0);
    chk("mid.cnt", 32'(seq_cnt), 0);
    clr = 1'b0; fin = 1'b0; halt = 1'b0; resume = 1'b0;
    step();
    chk_phase("mid.adv", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_gen_param.md
# seq_gen_param

Parametrised processor timing-state sequencer, successor to the fixed 4-state `seq_gen`. It steps a one-hot phase vector (plus its binary index) through a per-instruction programmable number of phases. It supports early termination, halt/resume and a completed-sequence counter. It sits in the control unit and drives the phase enables for fetch/decode/execute/writeback logic.

## Interface
- `NSTATES`, default 6: maximum phases per sequence; legal range 2..16.
- `CW`, default 8: width of the completed-sequence counter.
- `IW`, derived, not overridable: `IW = max(1, clog2(NSTATES))`.

- `clk` in 1: single clock; all state updates on its rising edge.
- `clr` in 1: synchronous, active-high reset.
- `ce` in 1: advance enable; when low, all state holds except `clr` and `resume` effects.
- `len` in IW+1: phase count for the next sequence; sampled only while `phase == 0`.
- `fin` in 1: end the current sequence early, returning to phase 0 after this phase.
- `halt` in 1: on completion of the current sequence, enter the halted condition.
- `resume` in 1: leave the halted condition.
- `state` out NSTATES: one-hot phase vector; bit `i` is set when `phase == i`.
- `phase` out IW: binary phase index.
- `first` out 1: `phase == 0 && !halted`.
- `last` out 1: current phase is the final phase of the sequence.
- `halted` out 1: sequencer is frozen at phase 0.
- `seq_cnt` out CW: number of sequences completed, modulo 2^CW.

## Operation
- **Effective length.**
  - `clamp(len)` is `len` when 1 ≤ `len` ≤ `NSTATES`; otherwise (0 or > `NSTATES`) it is `NSTATES`.
  - `eff_len = (phase == 0) ? clamp(len) : len_q`.
  - `len_q` is an internal register loaded with `clamp(len)` on every advancing edge that leaves phase 0.
- **`last`**: `!halted && phase == eff_len-1`. It is combinational from registers, plus `len` while in phase 0.
- **`adv`**: `ce && !halted && !clr`.
- **`done`**: `adv && (last || fin)`.
- **Next state**, highest priority first:
  1. `clr`: `phase` ← 0, `state` ← 1, `halted` ← 0, `seq_cnt` ← 0, `len_q` ← `NSTATES`.
  2. `halted && resume`: `halted` ← 0; phase is unchanged (it stays 0).
  3. `done`: `phase` ← 0; `seq_cnt` ← `seq_cnt`+1 (wraps); `halted` ← `halt`.
  4. `adv`: `phase` ← `phase`+1.
  5. Otherwise: hold.
- A sequence of length 1 stays at phase 0. Each `adv` cycle counts as one completed sequence.
- `fin` asserted in phase 0 completes a 1-phase sequence, identical to `len = 1`.
- `fin` and `last` together count as a single completion (`seq_cnt` increments by 1).
- `halt` is ignored unless `done` occurs in the same cycle. Assert it on the completing phase.
- `resume` is ignored when not halted, and works regardless of `ce`.
- While halted: `state = 1`, `phase = 0`, `first = 0`, `last = 0`. `ce`, `fin` and `halt` have no effect.
- Invariant: `state` is always exactly one-hot and equals `1 << phase`. It must never be 0 or multi-hot, including after `clr` mid-sequence.

## Timing
- **Reset values**: `state = 1`, `phase = 0`, `first = 1`, `last = (clamp(len) == 1)`, `halted = 0`, `seq_cnt = 0`.
- **Latency**: one cycle from an `adv` edge to the new `phase`/`state`. `first`, `last` and `halted` reflect the registered state in the same cycle.
- **`len` sampling**: `len` changes are ignored in phases ≥ 1 (`len_q` governs). In phase 0, `len` acts combinationally on `last`.
- **`clr` mid-sequence**: returns to phase 0 on the next edge and overrides `ce`, `fin`, `halt` and `resume` in that cycle.
- **`ce` low for k cycles**: the phase is held k extra cycles and `seq_cnt` is unchanged.

## Test plan
- **Full-length sequence**: `clr` for 1 cycle, `len = 6`, `ce = 1` for 13 cycles -> `phase` runs 0..5,0..5,0; `state` runs 000001..100000; `last` high at phase 5; `seq_cnt = 2`.
- **Short length, `ce` gaps**: `len = 3`, `ce` toggling 1,0,1,1,0,1 -> `phase` runs 0,1,1,2,0,0,1; `seq_cnt = 1`; `len` changed to 5 while in phase 1 has no effect until the next phase 0.
- **Early finish**: `len = 6`, `fin` pulsed in phase 2 -> next `phase` is 0; `seq_cnt` increments by 1; `fin` together with `last` in phase 5 increments by exactly 1.
- **Halt/resume**: `halt = 1` on the `last` phase -> `halted = 1`, `phase = 0`, `first = 0`, `last = 0` for 5 cycles with `ce = 1`; `resume` pulsed with `ce = 0` -> `halted = 0` the next cycle, then advances normally.
- **Length clamp and wrap**: `len = 0` or `len = 9` -> 6-phase sequence; `len = 1` -> phase stays 0 with `seq_cnt` incrementing every cycle, wrapping 255 -> 0 at `CW = 8`.
- **Reset mid-sequence**: `clr` asserted in phase 4 with `fin = halt = 1` -> next cycle `phase = 0`, `state = 000001`, `halted = 0`, `seq_cnt = 0`.
